// File: rtl/rename_map_table.sv
// Register rename: speculative/committed maps plus circular free list with one-cycle flush recovery.
// Lookups are combinational (0 cycles); rename_ready drops when the free list is empty or on flush; commits always accepted.
module rename_map_table #(
   parameter int ARCH_REGS = 32,
   parameter int PHYS_REGS = 64,
   parameter int AW        = $clog2(ARCH_REGS),
   parameter int PW        = $clog2(PHYS_REGS),
   parameter int FL_DEPTH  = PHYS_REGS - ARCH_REGS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rename_valid,
   output logic          rename_ready,
   input  logic          uses_rs,
   input  logic          uses_rt,
   input  logic          uses_rw,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   input  logic [AW-1:0] rw_addr,
   output logic [PW-1:0] rs_phys,
   output logic [PW-1:0] rt_phys,
   output logic [PW-1:0] rw_phys,
   output logic [PW-1:0] rw_old_phys,
   input  logic          commit_valid,
   input  logic          commit_uses_rw,
   input  logic [AW-1:0] commit_rw_addr,
   input  logic [PW-1:0] commit_rw_phys,
   input  logic [PW-1:0] commit_old_phys,
   input  logic          flush,
   output logic [PW:0]   free_count
);

   localparam int FW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
   localparam logic [PW:0] FL_FULL = (PW+1)'(FL_DEPTH);

   logic [PW-1:0] spec_map [ARCH_REGS];
   logic [PW-1:0] arch_map [ARCH_REGS];
   logic [PW-1:0] fl [FL_DEPTH];
   logic [FW-1:0] head;
   logic [FW-1:0] tail;
   logic [FW-1:0] commit_head;
   logic [PW:0]   count;

   logic rw_is_zero;
   logic fire;
   logic alloc;
   logic commit_en;
   logic unused_flags;

   function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
      return (p == FW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Source-use flags only qualify downstream wakeup; lookups are unconditional.
   assign unused_flags = uses_rs ^ uses_rt;

   assign rw_is_zero   = (rw_addr == '0);
   assign rename_ready = (count != '0) && !flush;
   assign fire         = rename_valid && rename_ready;
   assign alloc        = fire && uses_rw && !rw_is_zero;
   assign commit_en    = commit_valid && commit_uses_rw && (commit_rw_addr != '0);

   assign rs_phys     = spec_map[rs_addr];
   assign rt_phys     = spec_map[rt_addr];
   assign rw_phys     = rw_is_zero ? '0 : fl[head];
   assign rw_old_phys = rw_is_zero ? '0 : spec_map[rw_addr];
   assign free_count  = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            spec_map[i] <= PW'(i);
            arch_map[i] <= PW'(i);
         end
         for (int k = 0; k < FL_DEPTH; k++) begin
            fl[k] <= PW'(ARCH_REGS + k);
         end
         head        <= '0;
         tail        <= '0;
         commit_head <= '0;
         count       <= FL_FULL;
      end else begin
         if (commit_en) begin
            arch_map[commit_rw_addr] <= commit_rw_phys;
            fl[tail]                 <= commit_old_phys;
            tail                     <= ptr_inc(tail);
            commit_head              <= ptr_inc(commit_head);
         end
         if (flush) begin
            // Recovery must see this cycle's commit, so forward it into the copy.
            for (int i = 0; i < ARCH_REGS; i++) begin
               spec_map[i] <= (commit_en && commit_rw_addr == AW'(i)) ? commit_rw_phys : arch_map[i];
            end
            head  <= commit_en ? ptr_inc(commit_head) : commit_head;
            count <= FL_FULL;
         end else begin
            if (alloc) begin
               spec_map[rw_addr] <= fl[head];
               head              <= ptr_inc(head);
            end
            if (commit_en && !alloc) begin
               count <= count + 1'b1;
            end else if (alloc && !commit_en) begin
               count <= count - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rename_map_table.sv
// Bench for rename_map_table: directed vector table, hand-written corner sequences, random run against a queue model.
module tb_rename_map_table;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rename_valid, rename_ready;
   logic       uses_rs, uses_rt, uses_rw;
   logic [4:0] rs_addr, rt_addr, rw_addr;
   logic [5:0] rs_phys, rt_phys, rw_phys, rw_old_phys;
   logic       commit_valid, commit_uses_rw;
   logic [4:0] commit_rw_addr;
   logic [5:0] commit_rw_phys, commit_old_phys;
   logic       flush;
   logic [6:0] free_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rename_map_table dut (
      .clk(clk), .rst_n(rst_n),
      .rename_valid(rename_valid), .rename_ready(rename_ready),
      .uses_rs(uses_rs), .uses_rt(uses_rt), .uses_rw(uses_rw),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rw_addr(rw_addr),
      .rs_phys(rs_phys), .rt_phys(rt_phys), .rw_phys(rw_phys), .rw_old_phys(rw_old_phys),
      .commit_valid(commit_valid), .commit_uses_rw(commit_uses_rw),
      .commit_rw_addr(commit_rw_addr), .commit_rw_phys(commit_rw_phys),
      .commit_old_phys(commit_old_phys),
      .flush(flush), .free_count(free_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rn(input logic v, input logic u, input logic [4:0] rw, input logic [4:0] rs, input logic [4:0] rt);
      rename_valid = v; uses_rw = u; rw_addr = rw; rs_addr = rs; rt_addr = rt;
      uses_rs = 1'b1; uses_rt = 1'b1;
   endtask

   task automatic set_cm(input logic v, input logic u, input logic [4:0] a, input logic [5:0] p, input logic [5:0] o);
      commit_valid = v; commit_uses_rw = u; commit_rw_addr = a; commit_rw_phys = p; commit_old_phys = o;
   endtask

   task automatic idle();
      set_rn(0, 0, 0, 0, 0);
      set_cm(0, 0, 0, 0, 0);
      flush = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      #1;
   endtask

   // ---------------- reference model: maps as arrays, free lists as tag queues ----------------
   typedef struct { int a; int p; int o; } rob_t;
   int   m_spec [32];
   int   m_arch [32];
   int   m_sfree [$];
   int   m_afree [$];
   rob_t rob [$];

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin m_spec[i] = i; m_arch[i] = i; end
      m_sfree.delete(); m_afree.delete(); rob.delete();
      for (int k = 0; k < 32; k++) begin m_sfree.push_back(32 + k); m_afree.push_back(32 + k); end
   endtask

   task automatic m_check();
      int cnt = m_sfree.size();
      chk("rnd_ready", rename_ready, (cnt != 0) && !flush);
      chk("rnd_free", free_count, cnt);
      chk("rnd_rs", rs_phys, m_spec[rs_addr]);
      chk("rnd_rt", rt_phys, m_spec[rt_addr]);
      chk("rnd_rw_old", rw_old_phys, (rw_addr == 0) ? 0 : m_spec[rw_addr]);
      if (rw_addr == 0) chk("rnd_rw_zero", rw_phys, 0);
      else if (cnt > 0) chk("rnd_rw", rw_phys, m_sfree[0]);
   endtask

   task automatic m_step();
      bit rdy = (m_sfree.size() != 0) && !flush;
      bit al  = rename_valid && rdy && uses_rw && (rw_addr != 0);
      bit cen = commit_valid && commit_uses_rw && (commit_rw_addr != 0);
      int t;
      if (cen) begin
         m_arch[commit_rw_addr] = commit_rw_phys;
         void'(m_afree.pop_front());
         m_afree.push_back(commit_old_phys);
         m_sfree.push_back(commit_old_phys);
         void'(rob.pop_front());
      end
      if (al) begin
         t = m_sfree.pop_front();
         rob.push_back('{int'(rw_addr), t, m_spec[rw_addr]});
         m_spec[rw_addr] = t;
      end
      if (flush) begin
         m_spec  = m_arch;
         m_sfree = m_afree;
         rob.delete();
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic v; logic u; logic [4:0] rw; logic [4:0] rs;
      int e_rw; int e_old; int e_rs; int e_free; logic e_rdy;
   } vec_t;
   vec_t tbl [7];

   initial begin
      rst_n = 1'b0;
      idle();

      tbl[0] = '{1'b1, 1'b1, 5'd3, 5'd5, 32, 3,  5,  32, 1'b1};
      tbl[1] = '{1'b1, 1'b1, 5'd3, 5'd3, 33, 32, 32, 31, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 5'd0, 5'd3, 0,  0,  33, 30, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 5'd0, 5'd3, 0,  0,  33, 30, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 5'd7, 5'd3, 34, 7,  33, 30, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 5'd8, 5'd8, 34, 8,  8,  30, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 5'd8, 5'd8, 34, 8,  8,  30, 1'b1};

      // Reset defaults
      do_reset();
      rs_addr = 5'd5;
      #1;
      chk("reset_rs5", rs_phys, 5);
      chk("reset_free", free_count, 32);
      chk("reset_ready", rename_ready, 1);

      // Back-to-back renames, rw=0, non-allocating fire
      for (int i = 0; i < 7; i++) begin
         set_rn(tbl[i].v, tbl[i].u, tbl[i].rw, tbl[i].rs, tbl[i].rw);
         #1;
         chk($sformatf("tbl%0d_rw_phys", i), rw_phys, tbl[i].e_rw);
         chk($sformatf("tbl%0d_rw_old", i), rw_old_phys, tbl[i].e_old);
         chk($sformatf("tbl%0d_rt_phys", i), rt_phys, tbl[i].e_old);
         chk($sformatf("tbl%0d_rs_phys", i), rs_phys, tbl[i].e_rs);
         chk($sformatf("tbl%0d_free", i), free_count, tbl[i].e_free);
         chk($sformatf("tbl%0d_ready", i), rename_ready, tbl[i].e_rdy);
         cyc();
      end

      // Asynchronous reset mid-stream
      idle();
      rs_addr = 5'd3;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_rs3", rs_phys, 3);
      chk("midrst_free", free_count, 32);
      chk("midrst_ready", rename_ready, 1);
      rst_n = 1'b1;
      set_rn(1, 1, 3, 3, 3);
      #1;
      chk("midrst_alloc", rw_phys, 32);
      cyc();
      idle();

      // Exhaustion
      do_reset();
      for (int i = 0; i < 32; i++) begin
         set_rn(1, 1, 5'(((i + 2) % 31) + 1), 0, 0);
         cyc();
      end
      set_rn(1, 1, 5'd9, 5'd9, 5'd9);
      #1;
      chk("exh_free0", free_count, 0);
      chk("exh_ready0", rename_ready, 0);
      cyc();
      chk("exh_33rd_free", free_count, 0);
      chk("exh_33rd_map", rs_phys, 38);
      set_rn(1, 1, 5'd5, 5'd5, 5'd5);
      set_cm(1, 1, 5'd3, 6'd32, 6'd3);
      #1;
      chk("exh_commit_ready", rename_ready, 0);
      cyc();
      set_cm(0, 0, 0, 0, 0);
      #1;
      chk("exh_after_free", free_count, 1);
      chk("exh_after_ready", rename_ready, 1);
      chk("exh_after_rw", rw_phys, 3);
      set_cm(1, 1, 5'd4, 6'd33, 6'd4);
      cyc();
      idle();
      rs_addr = 5'd5; rw_addr = 5'd6;
      #1;
      chk("exh_both_free", free_count, 1);
      chk("exh_both_map", rs_phys, 3);
      chk("exh_both_next", rw_phys, 4);

      // Flush recovery with a two-cycle flush
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_rn(1, 1, 5'(3 + i), 0, 0);
         #1;
         chk($sformatf("fl_alloc%0d", i), rw_phys, 32 + i);
         cyc();
      end
      set_rn(0, 0, 0, 0, 0);
      set_cm(1, 1, 5'd3, 6'd32, 6'd3);
      cyc();
      set_cm(0, 0, 0, 0, 0);
      set_rn(1, 1, 5'd7, 0, 0);
      flush = 1'b1;
      #1;
      chk("fl_ready_c1", rename_ready, 0);
      cyc();
      chk("fl_ready_c2", rename_ready, 0);
      cyc();
      idle();
      for (int r = 3; r <= 7; r++) begin
         rs_addr = 5'(r);
         #1;
         chk($sformatf("fl_map_r%0d", r), rs_phys, (r == 3) ? 32 : r);
      end
      chk("fl_free", free_count, 32);
      chk("fl_ready", rename_ready, 1);
      set_rn(1, 1, 5'd6, 0, 0);
      #1;
      chk("fl_next_alloc", rw_phys, 33);
      cyc();

      // Random traffic against the queue model
      do_reset();
      m_reset();
      for (int n = 0; n < 3000; n++) begin
         int r;
         rename_valid = ($urandom_range(0, 9) < 7);
         uses_rw      = ($urandom_range(0, 7) != 0);
         uses_rs      = 1'($urandom_range(0, 1));
         uses_rt      = 1'($urandom_range(0, 1));
         rw_addr      = 5'($urandom_range(0, 31));
         rs_addr      = 5'($urandom_range(0, 31));
         rt_addr      = 5'($urandom_range(0, 31));
         r = $urandom_range(0, 9);
         if (rob.size() > 0 && r < 4)
            set_cm(1, 1, 5'(rob[0].a), 6'(rob[0].p), 6'(rob[0].o));
         else if (r == 4)
            set_cm(1, 0, 5'($urandom_range(1, 31)), 6'($urandom), 6'($urandom));
         else if (r == 5)
            set_cm(1, 1, 5'd0, 6'($urandom), 6'($urandom));
         else
            set_cm(0, 0, 0, 0, 0);
         flush = ($urandom_range(0, 31) == 0);
         #1;
         m_check();
         m_step();
         cyc();
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rename_map_table.md
# rename_map_table

Parametrised register rename stage for the out-of-order MIPS core. It sits between decode and issue, and translates architectural rs/rt/rw indices into physical register tags. It allocates a new physical destination from a circular free list and returns the previous mapping for release at commit. A committed (retirement) map and a committed free-list head allow single-cycle recovery on `flush`.

## Interface
Parameters:
- `ARCH_REGS`, 32, number of architectural registers; register 0 is hard-wired and never renamed.
- `PHYS_REGS`, 64, number of physical registers; must be greater than `ARCH_REGS`.
- `AW`, `$clog2(ARCH_REGS)`, architectural index width.
- `PW`, `$clog2(PHYS_REGS)`, physical tag width.
- `FL_DEPTH`, `PHYS_REGS-ARCH_REGS`, free-list depth (derived; do not override).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rename_valid`  in  1  decoded instruction presented for rename.
- `rename_ready`  out  1  rename can be accepted this cycle.
- `uses_rs`, `uses_rt`, `uses_rw`  in  1 each  operand-use flags from decode.
- `rs_addr`, `rt_addr`, `rw_addr`  in  AW each  architectural indices.
- `rs_phys`, `rt_phys`  out  PW each  current speculative mappings of rs and rt.
- `rw_phys`  out  PW  newly allocated destination tag.
- `rw_old_phys`  out  PW  previous mapping of rw, carried to the ROB.
- `commit_valid`  in  1  one instruction retires.
- `commit_uses_rw`  in  1  retiring instruction wrote a register.
- `commit_rw_addr`  in  AW  retiring destination (architectural).
- `commit_rw_phys`  in  PW  retiring destination (physical).
- `commit_old_phys`  in  PW  tag to return to the free list.
- `flush`  in  1  mispredict or exception: discard all uncommitted renames.
- `free_count`  out  PW+1  entries currently in the free list.

## Operation
- State:
  - speculative map `spec_map[ARCH_REGS]`;
  - committed map `arch_map[ARCH_REGS]`;
  - free-list array `fl[FL_DEPTH]` with `head` (allocate pointer), `tail` (release pointer) and `commit_head`;
  - `count`.
- Reset:
  - `spec_map[i]=arch_map[i]=i`;
  - `fl[k]=ARCH_REGS+k`;
  - `head=tail=commit_head=0`;
  - `count=FL_DEPTH`.
- Lookup (combinational, no bypass):
  - `rs_phys=spec_map[rs_addr]`, `rt_phys=spec_map[rt_addr]`;
  - `rw_old_phys=spec_map[rw_addr]`, `rw_phys=fl[head]`.
  - Sources read pre-update state, so an instruction whose sources equal its own rw sees the old mapping.
  - Outputs are valid regardless of `uses_*`. When the rw-is-0 case applies, `rw_phys` and `rw_old_phys` are 0.
- `rename_ready = (count!=0) && !flush`, from the registered count only.
- Rename fire = `rename_valid && rename_ready`.
- Allocation condition = fire && `uses_rw` && `rw_addr!=0`. When it holds:
  - `spec_map[rw_addr] <= fl[head]`;
  - `head` advances modulo `FL_DEPTH`;
  - `count` decrements.
- Fire with no allocation changes no state.
- Commit condition = `commit_valid` && `commit_uses_rw` && `commit_rw_addr!=0`. When it holds:
  - `arch_map[commit_rw_addr] <= commit_rw_phys`;
  - `fl[tail] <= commit_old_phys`, and `tail` advances modulo `FL_DEPTH`;
  - `commit_head` advances modulo `FL_DEPTH`;
  - `count` increments.
- Commits are always accepted. The ROB guarantees that commits are in order and correspond to prior allocations.
- Flush takes effect on the next edge:
  - `spec_map <= arch_map`, including a same-cycle commit write;
  - `head <= commit_head`, including a same-cycle commit advance;
  - `count <= FL_DEPTH`; the committed free list always holds exactly `FL_DEPTH` entries.
  - Any rename in the flush cycle is dropped, because `rename_ready=0`.

## Timing
- Lookup latency is 0 cycles. A map or free-list update is visible to the next cycle's lookup.
- Rename and commit in the same cycle: both are applied, and `count` is unchanged.
- When `count==0`, `rename_ready=0` even if a commit frees an entry that cycle. Ready rises on the following cycle.
- `count` never exceeds `FL_DEPTH` and never underflows. The pointers wrap from `FL_DEPTH-1` to 0.
- Asserting `rst_n` low mid-operation immediately restores all reset state. The outputs then reflect the identity map: `rename_ready=1` and `free_count=FL_DEPTH`.
- Flush held for multiple cycles: each cycle re-copies committed state, and `rename_ready` stays 0 throughout.

## Test plan
1. Reset, defaults (32/64):
   - `rs_addr=5` -> `rs_phys=5`;
   - `free_count=32`, `rename_ready=1`.
2. Rename rw=3 twice back-to-back:
   - first gives `rw_phys=32`, `rw_old_phys=3`;
   - second gives `rw_phys=33`, `rw_old_phys=32`;
   - then `rs_addr=3` -> `rs_phys=33`, and `free_count=30`.
3. Rename rw=0 with `uses_rw=1`:
   - `rw_phys=0`;
   - `free_count` unchanged and no map change.
4. Exhaustion:
   - 32 allocating renames -> `free_count=0`, `rename_ready=0`;
   - a 33rd `rename_valid` changes nothing;
   - a commit returning phys 3 gives `free_count=1` and `rename_ready=1` next cycle;
   - a rename and a commit in the same cycle leave `count` unchanged.
5. Flush recovery:
   - rename r3->32, r4->33, r5->34;
   - commit (3, 32, old 3);
   - flush -> r3->32, r4->4, r5->5, `free_count=32`;
   - next rename allocates 33.
6. Reset asserted mid-stream, after case 2:
   - identity map is restored, `free_count=32`;
   - the next rename allocates 32.
